// File: rtl/run_monitor.sv
// Program-run monitor: watches the fetch PC after a start pulse, counts RUN cycles,
// declares DONE after LOOP_HITS end_pc hits, flags forbidden PCs and times out.
module run_monitor #(
   parameter int ADDR_W     = 32,
   parameter int NUM_FORBID = 4,
   parameter int LOOP_HITS  = 5,
   parameter int HIT_W      = 4,
   parameter int MAX_CYCLES = 64,
   parameter int CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDR_W-1:0]            pc,
   input  logic                         pc_valid,
   input  logic [ADDR_W-1:0]            end_pc,
   input  logic [NUM_FORBID*ADDR_W-1:0] forbid_pc,
   input  logic [NUM_FORBID-1:0]        forbid_en,
   output logic                         busy,
   output logic                         done,
   output logic                         timeout,
   output logic                         pass,
   output logic [NUM_FORBID-1:0]        violation,
   output logic [CNT_W-1:0]             cycle_count,
   output logic [HIT_W-1:0]             hit_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   localparam logic [HIT_W-1:0] HIT_ONE    = HIT_W'(1);
   localparam logic [HIT_W-1:0] HIT_TARGET = HIT_W'(LOOP_HITS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

   state_t                r_state;
   state_t                w_state_next;
   logic [CNT_W-1:0]      r_cycle_count;
   logic [HIT_W-1:0]      r_hit_count;
   logic [NUM_FORBID-1:0] r_violation;

   logic                  w_end_hit;
   logic [NUM_FORBID-1:0] w_forbid_hit;
   logic [HIT_W-1:0]      w_hit_inc;
   logic                  w_final_hit;
   logic                  w_timeout_edge;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FORBID; gi++) begin : g_forbid
         assign w_forbid_hit[gi] = pc_valid & forbid_en[gi] &
                                   (pc == forbid_pc[gi*ADDR_W +: ADDR_W]);
      end
   endgenerate

   assign w_end_hit      = pc_valid & (pc == end_pc);
   assign w_hit_inc      = r_hit_count + HIT_ONE;
   assign w_final_hit    = w_end_hit & (w_hit_inc == HIT_TARGET);
   assign w_timeout_edge = (r_cycle_count == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A final hit on the timeout edge takes priority over the timeout.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_RUN: begin
            if (w_final_hit) begin
               w_state_next = S_DONE;
            end else if (w_timeout_edge) begin
               w_state_next = S_FAIL;
            end
         end
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               w_state_next = S_RUN;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // The cycle counter stops at MAX_CYCLES-1: the edge that leaves RUN for FAIL does not count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle_count <= '0;
         r_hit_count   <= '0;
         r_violation   <= '0;
      end else if (r_state == S_RUN) begin
         if (!w_timeout_edge && (r_cycle_count != CNT_SAT)) begin
            r_cycle_count <= r_cycle_count + CNT_ONE;
         end
         if (w_end_hit) begin
            r_hit_count <= w_hit_inc;
         end
         r_violation <= r_violation | w_forbid_hit;
      end else if (start) begin
         r_cycle_count <= '0;
         r_hit_count   <= '0;
         r_violation   <= '0;
      end
   end

   assign busy        = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign timeout     = (r_state == S_FAIL);
   assign pass        = done & ~|r_violation;
   assign violation   = r_violation;
   assign cycle_count = r_cycle_count;
   assign hit_count   = r_hit_count;

endmodule

// File: tb/tb_run_monitor.sv
// Scoreboard bench for run_monitor: the driver pushes model expectations after each edge,
// an independent monitor pops and compares them on the falling edge.
module tb_run_monitor;

   localparam int ADDR_W     = 32;
   localparam int NUM_FORBID = 4;
   localparam int LOOP_HITS  = 5;
   localparam int HIT_W      = 4;
   localparam int MAX_CYCLES = 64;
   localparam int CNT_W      = 16;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         start;
   logic [ADDR_W-1:0]            pc;
   logic                         pc_valid;
   logic [ADDR_W-1:0]            end_pc;
   logic [NUM_FORBID*ADDR_W-1:0] forbid_pc;
   logic [NUM_FORBID-1:0]        forbid_en;
   logic                         busy;
   logic                         done;
   logic                         timeout;
   logic                         pass;
   logic [NUM_FORBID-1:0]        violation;
   logic [CNT_W-1:0]             cycle_count;
   logic [HIT_W-1:0]             hit_count;

   run_monitor #(
      .ADDR_W(ADDR_W), .NUM_FORBID(NUM_FORBID), .LOOP_HITS(LOOP_HITS),
      .HIT_W(HIT_W), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_valid(pc_valid),
      .end_pc(end_pc), .forbid_pc(forbid_pc), .forbid_en(forbid_en),
      .busy(busy), .done(done), .timeout(timeout), .pass(pass),
      .violation(violation), .cycle_count(cycle_count), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       busy;
      bit       done;
      bit       timeout;
      bit       pass;
      bit [3:0] viol;
      int       cyc;
      int       hit;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   txn      = 0;

   // Reference model: running / finished-ok / finished-timeout flags plus plain integer counts.
   bit       m_run, m_done, m_fail;
   bit [3:0] m_viol;
   int       m_cyc, m_hit;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_run = 0; m_done = 0; m_fail = 0; m_viol = 0; m_cyc = 0; m_hit = 0;
   endfunction

   function automatic void model_edge();
      bit fin;
      int old;
      fin = 0;
      if (rst) begin
         model_reset();
         return;
      end
      if (!m_run) begin
         if (start) begin
            m_run = 1; m_done = 0; m_fail = 0; m_viol = 0; m_cyc = 0; m_hit = 0;
         end
         return;
      end
      old = m_cyc;
      if (pc_valid) begin
         if (pc == end_pc) begin
            m_hit = m_hit + 1;
            fin = (m_hit == LOOP_HITS);
         end
         for (int k = 0; k < NUM_FORBID; k++) begin
            if (forbid_en[k] && pc == forbid_pc[k*ADDR_W +: ADDR_W]) m_viol[k] = 1'b1;
         end
      end
      m_cyc = (old + 1 < MAX_CYCLES) ? old + 1 : MAX_CYCLES - 1;
      if (fin) begin
         m_run = 0; m_done = 1;
      end else if (old == MAX_CYCLES - 1) begin
         m_run = 0; m_fail = 1;
      end
   endfunction

   function automatic void push_expect();
      exp_t e;
      e.busy    = m_run;
      e.done    = m_done;
      e.timeout = m_fail;
      e.pass    = m_done && (m_viol == 0);
      e.viol    = m_viol;
      e.cyc     = m_cyc;
      e.hit     = m_hit;
      q.push_back(e);
   endfunction

   // One cycle: drive inputs now (falling edge), let the rising edge happen, record expectation.
   task automatic step(bit st, logic [ADDR_W-1:0] p, bit v);
      start    = st;
      pc       = p;
      pc_valid = v;
      @(posedge clk);
      model_edge();
      push_expect();
      @(negedge clk);
   endtask

   task automatic check_zero(string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_violation"}, violation, 0);
      check({tag, "_cycle_count"}, cycle_count, 0);
      check({tag, "_hit_count"}, hit_count, 0);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            txn++;
            $display("txn %0d: busy=%0b done=%0b timeout=%0b pass=%0b viol=%b cyc=%0d hit=%0d",
                     txn, busy, done, timeout, pass, violation, cycle_count, hit_count);
            check("busy", busy, mon_e.busy);
            check("done", done, mon_e.done);
            check("timeout", timeout, mon_e.timeout);
            check("pass", pass, mon_e.pass);
            check("violation", violation, mon_e.viol);
            check("cycle_count", cycle_count, mon_e.cyc);
            check("hit_count", hit_count, mon_e.hit);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin : driver
      rst = 1'b1; start = 1'b0; pc = '0; pc_valid = 1'b0;
      end_pc = 32'd116; forbid_pc = '0; forbid_en = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("reset_hold");
      rst = 1'b0;
      step(0, 0, 0);

      // 1: ramp to the end loop then spin there; done one cycle after the 5th hit.
      step(1, 0, 0);
      for (int i = 0; i < 29; i++) step(0, 32'(i * 4), 1);
      repeat (5) step(0, 116, 1);
      check("s1_done", done, 1);
      check("s1_hit_count", hit_count, 5);
      check("s1_pass", pass, 1);
      repeat (2) step(0, 0, 0);

      // 2 and 6: restart from DONE with forbidden PC 36 on channel 0.
      forbid_pc[31:0] = 32'd36;
      forbid_en       = 4'b0001;
      step(1, 0, 0);
      check("s6_busy", busy, 1);
      check("s6_hit_clear", hit_count, 0);
      check("s6_viol_clear", violation, 0);
      for (int i = 0; i < 29; i++) step(0, 32'(i * 4), 1);
      repeat (5) step(0, 116, 1);
      check("s2_done", done, 1);
      check("s2_violation", violation, 1);
      check("s2_pass", pass, 0);

      // 3: end_pc never seen -> timeout.
      forbid_en = '0;
      step(1, 0, 0);
      repeat (70) step(0, 200, 1);
      check("s3_timeout", timeout, 1);
      check("s3_cycle_count", cycle_count, MAX_CYCLES - 1);
      check("s3_done", done, 0);

      // 4: fifth hit lands on the timeout edge -> done wins.
      step(1, 0, 0);
      for (int i = 0; i < MAX_CYCLES; i++) step(0, (i >= MAX_CYCLES - 5) ? 32'd116 : 32'd8, 1);
      check("s4_done", done, 1);
      check("s4_timeout", timeout, 0);
      check("s4_hit_count", hit_count, 5);

      // 5: stalled fetches at end_pc do not count; async reset mid-RUN clears everything.
      step(1, 0, 0);
      repeat (10) step(0, 116, 0);
      check("s5_hit_count", hit_count, 0);
      check("s5_busy", busy, 1);
      check("s5_cycle_count", cycle_count, 10);
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      model_reset();
      step(0, 0, 0);
      rst = 1'b0;
      step(0, 0, 0);

      // Randomised traffic against the model.
      for (int blk = 0; blk < 8; blk++) begin
         end_pc = 32'(4 * $urandom_range(0, 15));
         for (int k = 0; k < NUM_FORBID; k++) begin
            forbid_pc[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 3) == 0) ? end_pc
                                            : 32'(4 * $urandom_range(0, 15));
         end
         forbid_en = 4'($urandom_range(0, 15));
         for (int c = 0; c < 60; c++) begin
            int  sel;
            bit  st;
            bit  v;
            logic [ADDR_W-1:0] p;
            st  = ($urandom_range(0, 19) == 0);
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 5);
            if (sel < 2) p = end_pc;
            else if (sel < 4) p = forbid_pc[$urandom_range(0, NUM_FORBID - 1)*ADDR_W +: ADDR_W];
            else p = 32'(4 * $urandom_range(0, 15));
            step(st, p, v);
         end
      end

      repeat (2) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
